// File: rtl/axis_pattern_source_if.sv
// AXI4-Stream bundle driven by the pattern source.
interface axis_pattern_source_if #(
    parameter int unsigned DATA_SIZE = 32
);
    logic [DATA_SIZE-1:0]   tdata;
    logic [DATA_SIZE/8-1:0] tstrb;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pattern_source.sv
// Packetising AXIS test-pattern generator (inc/const/walking-one/dec) feeding a FWFT FIFO.
module axis_pattern_source #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  m00_axis_aclk,
    input  logic                  m00_axis_areset,
    input  logic                  m00_axis_enable,
    input  logic [1:0]            cfg_mode,
    input  logic [DATA_SIZE-1:0]  cfg_seed,
    input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
    input  logic [LEN_WIDTH-1:0]  cfg_num_pkts,
    axis_pattern_source_if.master m00_axis,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned Depth = 1 << ADDR_WIDTH;
    localparam logic [DATA_SIZE-1:0] DataOne = 1;
    localparam logic [LEN_WIDTH-1:0] LenOne  = 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [LEN_WIDTH-1:0] word_q, word_d;
    logic [LEN_WIDTH-1:0] pkt_q, pkt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] num_q, num_d;
    logic [1:0]           mode_q, mode_d;

    logic [DATA_SIZE:0]   mem_q [Depth];
    logic [ADDR_WIDTH:0]  wr_ptr_q, rd_ptr_q;
    logic                 empty, full, wr_en, rd_en, last_bit;
    logic [DATA_SIZE:0]   rd_word;
    logic [DATA_SIZE-1:0] next_data;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    // Full is judged on the current pointers, so a same-cycle read cannot make room.
    assign wr_en = (state_q == StRun) && !full;
    assign rd_en = !empty && m00_axis.tready;
    assign last_bit = (word_q == len_q - LenOne);

    assign rd_word           = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign m00_axis.tvalid   = !empty;
    assign m00_axis.tdata    = empty ? '0 : rd_word[DATA_SIZE-1:0];
    assign m00_axis.tlast    = empty ? 1'b0 : rd_word[DATA_SIZE];
    assign m00_axis.tstrb    = empty ? '0 : '1;
    assign fifo_level        = wr_ptr_q - rd_ptr_q;
    assign busy              = (state_q != StIdle);
    assign done              = (state_q == StDrain) && empty;

    always_comb begin
        next_data = data_q;
        unique case (mode_q)
            2'd0:    next_data = data_q + DataOne;
            2'd1:    next_data = data_q;
            2'd2:    next_data = {data_q[DATA_SIZE-2:0], data_q[DATA_SIZE-1]};
            default: next_data = data_q - DataOne;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        word_d  = word_q;
        pkt_d   = pkt_q;
        len_d   = len_q;
        num_d   = num_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (m00_axis_enable) begin
                    mode_d  = cfg_mode;
                    num_d   = cfg_num_pkts;
                    len_d   = (cfg_pkt_len == '0) ? LenOne : cfg_pkt_len;
                    data_d  = (cfg_mode == 2'd2 && cfg_seed == '0) ? DataOne : cfg_seed;
                    word_d  = '0;
                    pkt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (wr_en) begin
                    data_d = next_data;
                    if (last_bit) begin
                        word_d = '0;
                        pkt_d  = pkt_q + LenOne;
                        if ((num_q != '0 && pkt_q == num_q - LenOne) || !m00_axis_enable) begin
                            state_d = StDrain;
                        end
                    end else begin
                        word_d = word_q + LenOne;
                    end
                end
            end
            StDrain: begin
                if (empty) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state_q  <= StIdle;
            data_q   <= '0;
            word_q   <= '0;
            pkt_q    <= '0;
            len_q    <= '0;
            num_q    <= '0;
            mode_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            word_q  <= word_d;
            pkt_q   <= pkt_d;
            len_q   <= len_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (wr_en && !m00_axis_areset) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {last_bit, data_q};
        end
    end
endmodule
